// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU serial command front end.
//   op_t      : legal ALU opcodes
//   cmd_t     : byte frame type bit (DATA / CTL)
//   err_t     : one-hot error report {ERR_DATA, ERR_CRC, ERR_OP}
//   report_t  : payload presented to the ALU core
//   crc4()    : CRC-4 (x^4+x+1, init 0, MSB first) over {B, A, 1'b1, OP}
//   op_legal(): opcode membership check
package alu_pkg;

    localparam int unsigned NUM_DATA_BYTES = 8;
    localparam int unsigned CRC_W          = 4;
    localparam int unsigned FRAME_BITS     = 11;
    localparam int unsigned OPERAND_W      = 32;
    localparam int unsigned OP_W           = 3;
    localparam int unsigned ERR_W          = 3;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned CRC_IN_W       = 2 * OPERAND_W + 1 + OP_W;

    localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;

    typedef enum logic [OP_W-1:0] {
        AND_OP = 3'b000,
        OR_OP  = 3'b001,
        ADD_OP = 3'b100,
        SUB_OP = 3'b101
    } op_t;

    typedef enum logic {
        DATA = 1'b0,
        CTL  = 1'b1
    } cmd_t;

    typedef logic [ERR_W-1:0] err_t;

    localparam err_t ERR_NONE = 3'b000;
    localparam err_t ERR_DATA = 3'b100;
    localparam err_t ERR_CRC  = 3'b010;
    localparam err_t ERR_OP   = 3'b001;

    typedef struct packed {
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
        logic [OP_W-1:0]      op;
        err_t                 err;
    } report_t;

    // Bit-serial LFSR form, MSB of the input vector enters first.
    function automatic logic [CRC_W-1:0] crc4(input logic [CRC_IN_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = '0;
        for (int i = int'(CRC_IN_W) - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_W'(0));
        end
        return c;
    endfunction

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        case (op)
            AND_OP, OR_OP, ADD_OP, SUB_OP: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_serial_byte_rx.sv
// Byte framer for the serial command stream.
// Frame: start(0), type, 8 data bits MSB first, stop(1). One bit per clk.
// Ports:
//   clk, RST   : clock, synchronous active-high reset
//   sin        : serial input, idles high
//   byte_valid : high during the stop-bit cycle when the stop bit is 1
//   frame_err  : high during the stop-bit cycle when the stop bit is 0
//   byte_type  : latched type bit of the current frame
//   byte_data  : assembled data byte, stable while byte_valid is high
// byte_valid/frame_err are decoded from the STOP state and sin so the
// top can register its report on the very edge that samples the stop bit.
module alu_serial_byte_rx
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              RST,
    input  logic              sin,
    output logic              byte_valid,
    output cmd_t              byte_type,
    output logic [BYTE_W-1:0] byte_data,
    output logic              frame_err
);

    localparam int unsigned DATA_BITS = FRAME_BITS - 3;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TYPE,
        S_BITS,
        S_STOP
    } rx_state_t;

    rx_state_t              state;
    logic [BIT_CNT_W-1:0]   bit_cnt;

    // Frame sequencer; the stop state always returns to IDLE so a start
    // bit in the next cycle begins a new frame.
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            byte_type <= DATA;
            byte_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!sin) begin
                        state <= S_TYPE;
                    end
                end
                S_TYPE: begin
                    byte_type <= cmd_t'(sin);
                    bit_cnt   <= '0;
                    state     <= S_BITS;
                end
                S_BITS: begin
                    byte_data <= {byte_data[BYTE_W-2:0], sin};
                    bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stop-bit qualification.
    assign byte_valid = (state == S_STOP) &&  sin;
    assign frame_err  = (state == S_STOP) && !sin;

endmodule

// File: rtl/alu_cmd_deserializer.sv
// Serial command front end of the ALU: assembles 8 DATA bytes (B then A,
// MSB first) and a CTL byte {0, OP, CRC4}, checks framing, structure, CRC
// and opcode, and presents the result over a valid/ready handshake.
// Ports:
//   clk, RST  : clock, synchronous active-high reset
//   sin       : serial input, idles high
//   out_valid : report pending; held with its data until out_ready
//   out_ready : core accepts the report when out_valid & out_ready
//   out_A/B   : operands (signed 32-bit)
//   out_OP    : opcode
//   out_err   : {ERR_DATA, ERR_CRC, ERR_OP}, at most one bit set
//   out_ovr   : sticky, a report was dropped while the output was occupied
module alu_cmd_deserializer
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 sin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPERAND_W-1:0] out_A,
    output logic [OPERAND_W-1:0] out_B,
    output logic [OP_W-1:0]      out_OP,
    output logic [ERR_W-1:0]     out_err,
    output logic                 out_ovr
);

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned HALF_PKT  = NUM_DATA_BYTES / 2;

    logic              byte_valid;
    logic              frame_err;
    cmd_t              byte_type;
    logic [BYTE_W-1:0] byte_data;

    logic [CNT_W-1:0]     byte_cnt;
    logic [OPERAND_W-1:0] sh_a;
    logic [OPERAND_W-1:0] sh_b;

    logic [OP_W-1:0]  ctl_op_c;
    logic [CRC_W-1:0] ctl_crc_c;
    logic [CRC_W-1:0] crc_calc_c;
    logic             pkt_full_c;

    logic    shift_en_c;
    logic    pkt_done_c;
    logic    rpt_fire_c;
    report_t rpt_c;
    logic    out_free_c;

    alu_serial_byte_rx u_byte_rx (
        .clk        (clk),
        .RST        (RST),
        .sin        (sin),
        .byte_valid (byte_valid),
        .byte_type  (byte_type),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign ctl_op_c   = byte_data[6:4];
    assign ctl_crc_c  = byte_data[CRC_W-1:0];
    assign crc_calc_c = crc4({sh_b, sh_a, 1'b1, ctl_op_c});
    assign pkt_full_c = (byte_cnt == CNT_W'(NUM_DATA_BYTES));

    // Slot is free if empty or being handed to the core this cycle.
    assign out_free_c = !out_valid || out_ready;

    // Byte classification and report construction; DATA > CRC > OP.
    always_comb begin
        shift_en_c = 1'b0;
        pkt_done_c = 1'b0;
        rpt_fire_c = 1'b0;
        rpt_c      = '{a: sh_a, b: sh_b, op: '0, err: ERR_NONE};

        if (frame_err) begin
            pkt_done_c = 1'b1;
            rpt_fire_c = 1'b1;
            rpt_c.err  = ERR_DATA;
        end else if (byte_valid) begin
            if (byte_type == DATA) begin
                if (pkt_full_c) begin
                    pkt_done_c = 1'b1;
                    rpt_fire_c = 1'b1;
                    rpt_c.err  = ERR_DATA;
                end else begin
                    shift_en_c = 1'b1;
                end
            end else begin
                pkt_done_c = 1'b1;
                rpt_fire_c = 1'b1;
                rpt_c.op   = ctl_op_c;
                if (!pkt_full_c) begin
                    rpt_c.err = ERR_DATA;
                end else if (ctl_crc_c != crc_calc_c) begin
                    rpt_c.err = ERR_CRC;
                end else if (!op_legal(ctl_op_c)) begin
                    rpt_c.err = ERR_OP;
                end
            end
        end
    end

    // Packet assembly and output holding register.
    always_ff @(posedge clk) begin
        if (RST) begin
            byte_cnt  <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            out_valid <= 1'b0;
            out_A     <= '0;
            out_B     <= '0;
            out_OP    <= '0;
            out_err   <= ERR_NONE;
            out_ovr   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (shift_en_c) begin
                if (byte_cnt < CNT_W'(HALF_PKT)) begin
                    sh_b <= {sh_b[OPERAND_W-BYTE_W-1:0], byte_data};
                end else begin
                    sh_a <= {sh_a[OPERAND_W-BYTE_W-1:0], byte_data};
                end
                byte_cnt <= byte_cnt + CNT_W'(1);
            end

            // Any terminating byte (good or bad) starts a fresh packet.
            if (pkt_done_c) begin
                byte_cnt <= '0;
                sh_a     <= '0;
                sh_b     <= '0;
            end

            if (rpt_fire_c) begin
                if (out_free_c) begin
                    out_valid <= 1'b1;
                    out_A     <= rpt_c.a;
                    out_B     <= rpt_c.b;
                    out_OP    <= rpt_c.op;
                    out_err   <= rpt_c.err;
                end else begin
                    out_ovr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_deserializer.sv
// Directed bench for alu_cmd_deserializer: a table of packets with
// hand-written expected reports, plus sequences for handshake, overrun,
// reset and framing corner cases.
module tb_alu_cmd_deserializer;

    logic        clk = 1'b0;
    logic        RST;
    logic        sin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_A;
    logic [31:0] out_B;
    logic [2:0]  out_OP;
    logic [2:0]  out_err;
    logic        out_ovr;

    int n_vec  = 0;
    int n_miss = 0;

    alu_cmd_deserializer dut (
        .clk       (clk),
        .RST       (RST),
        .sin       (sin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_A     (out_A),
        .out_B     (out_B),
        .out_OP    (out_OP),
        .out_err   (out_err),
        .out_ovr   (out_ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        bit          bad_crc;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t vecs[9];

    // Reference CRC by polynomial long division (x^4+x+1 = 5'b10011).
    function automatic logic [3:0] ref_crc(input logic [67:0] d);
        logic [71:0] r;
        r = {d, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_byte(input logic typ, input logic [7:0] d, input logic stop, input bit raise_rdy);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        @(negedge clk);
        sin = stop;
        if (raise_rdy) out_ready = 1'b1;
    endtask

    task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                               input bit bad, input bit raise_rdy);
        logic [3:0] c;
        c = ref_crc({b, a, (bad ? 1'b0 : 1'b1), op});
        for (int i = 3; i >= 0; i--) send_byte(1'b0, b[i*8 +: 8], 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) send_byte(1'b0, a[i*8 +: 8], 1'b1, 1'b0);
        send_byte(1'b1, {1'b0, op, c}, 1'b1, raise_rdy);
    endtask

    // Report must appear one cycle after the stop bit and, with out_ready
    // high, last exactly one cycle.
    task automatic expect_report(input string nm, input logic [2:0] exp_err, input bit chk_payload,
                                 input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] eop);
        @(posedge clk); #1;
        check({nm, ".valid"}, 32'(out_valid), 32'd1);
        check({nm, ".err"}, 32'(out_err), 32'(exp_err));
        if (chk_payload) begin
            check({nm, ".A"}, out_A, ea);
            check({nm, ".B"}, out_B, eb);
            check({nm, ".OP"}, 32'(out_OP), 32'(eop));
        end
        @(negedge clk);
        sin = 1'b1;
        @(posedge clk); #1;
        check({nm, ".drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic check_zero(input string nm);
        check({nm, ".valid"}, 32'(out_valid), 32'd0);
        check({nm, ".A"}, out_A, 32'd0);
        check({nm, ".B"}, out_B, 32'd0);
        check({nm, ".OP"}, 32'(out_OP), 32'd0);
        check({nm, ".err"}, 32'(out_err), 32'd0);
        check({nm, ".ovr"}, 32'(out_ovr), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{b: 32'h0000_0003, a: 32'h0000_0005, op: 3'b100, bad_crc: 1'b0, exp_err: 3'b000};
        vecs[1] = '{b: 32'h0000_0003, a: 32'h0000_0005, op: 3'b100, bad_crc: 1'b1, exp_err: 3'b010};
        vecs[2] = '{b: 32'hFFFF_FFFF, a: 32'h0000_0001, op: 3'b010, bad_crc: 1'b0, exp_err: 3'b001};
        vecs[3] = '{b: 32'h8000_0000, a: 32'hFFFF_FFFE, op: 3'b101, bad_crc: 1'b0, exp_err: 3'b000};
        vecs[4] = '{b: 32'h1234_5678, a: 32'h9ABC_DEF0, op: 3'b000, bad_crc: 1'b0, exp_err: 3'b000};
        vecs[5] = '{b: 32'h0000_0000, a: 32'h0000_0000, op: 3'b001, bad_crc: 1'b0, exp_err: 3'b000};
        vecs[6] = '{b: 32'h0000_0001, a: 32'h0000_0002, op: 3'b111, bad_crc: 1'b1, exp_err: 3'b010};
        vecs[7] = '{b: 32'h0000_0001, a: 32'h0000_0002, op: 3'b110, bad_crc: 1'b0, exp_err: 3'b001};
        vecs[8] = '{b: 32'hDEAD_BEEF, a: 32'h0000_0000, op: 3'b011, bad_crc: 1'b0, exp_err: 3'b001};

        RST = 1'b1;
        sin = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        RST = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven packets, out_ready held high.
        for (int v = 0; v < 9; v++) begin
            send_packet(vecs[v].b, vecs[v].a, vecs[v].op, vecs[v].bad_crc, 1'b0);
            expect_report($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_err == 3'b000,
                          vecs[v].a, vecs[v].b, vecs[v].op);
        end

        // CTL in place of B byte 3, then a clean packet.
        send_byte(1'b0, 8'h00, 1'b1, 1'b0);
        send_byte(1'b0, 8'h00, 1'b1, 1'b0);
        send_byte(1'b0, 8'h00, 1'b1, 1'b0);
        send_byte(1'b1, 8'h02, 1'b1, 1'b0);
        expect_report("early_ctl", 3'b100, 1'b0, 32'd0, 32'd0, 3'd0);
        send_packet(32'd2, 32'd1, 3'b000, 1'b0, 1'b0);
        expect_report("after_early_ctl", 3'b000, 1'b1, 32'd1, 32'd2, 3'b000);

        // Ninth DATA byte.
        for (int i = 0; i < 9; i++) send_byte(1'b0, 8'hA5, 1'b1, 1'b0);
        expect_report("ninth_data", 3'b100, 1'b0, 32'd0, 32'd0, 3'd0);

        // Overrun: two reports with out_ready low.
        @(negedge clk);
        out_ready = 1'b0;
        send_packet(32'h0000_0011, 32'h0000_0022, 3'b100, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("ovr1.valid", 32'(out_valid), 32'd1);
        check("ovr1.ovr", 32'(out_ovr), 32'd0);
        send_packet(32'h0000_0033, 32'h0000_0044, 3'b101, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("ovr2.ovr", 32'(out_ovr), 32'd1);
        check("ovr2.valid", 32'(out_valid), 32'd1);
        check("ovr2.A", out_A, 32'h0000_0022);
        check("ovr2.B", out_B, 32'h0000_0011);
        check("ovr2.OP", 32'(out_OP), 32'(3'b100));
        check("ovr2.err", 32'(out_err), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("ovr_accept.valid", 32'(out_valid), 32'd0);
        check("ovr_accept.ovr", 32'(out_ovr), 32'd1);

        // Reset after four DATA bytes discards the partial packet.
        for (int i = 0; i < 4; i++) send_byte(1'b0, 8'h5A, 1'b1, 1'b0);
        @(negedge clk);
        RST = 1'b1;
        @(posedge clk); #1;
        check_zero("mid_rst");
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        send_packet(32'd9, 32'd7, 3'b001, 1'b0, 1'b0);
        expect_report("post_rst", 3'b000, 1'b1, 32'd7, 32'd9, 3'b001);
        check("post_rst.ovr", 32'(out_ovr), 32'd0);

        // Stop bit forced low in a DATA byte.
        send_byte(1'b0, 8'h55, 1'b1, 1'b0);
        send_byte(1'b0, 8'h55, 1'b0, 1'b0);
        expect_report("frame_err", 3'b100, 1'b0, 32'd0, 32'd0, 3'd0);
        send_packet(32'hFFFF_FFF6, 32'h0000_0064, 3'b101, 1'b0, 1'b0);
        expect_report("after_frame_err", 3'b000, 1'b1, 32'h0000_0064, 32'hFFFF_FFF6, 3'b101);

        // New report in the same cycle as the previous handshake: loaded, no overrun.
        @(negedge clk);
        out_ready = 1'b0;
        send_packet(32'h0000_00AA, 32'h0000_00BB, 3'b000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("same_cyc1.valid", 32'(out_valid), 32'd1);
        send_packet(32'h0000_00CC, 32'h0000_00DD, 3'b001, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("same_cyc2.valid", 32'(out_valid), 32'd1);
        check("same_cyc2.A", out_A, 32'h0000_00DD);
        check("same_cyc2.B", out_B, 32'h0000_00CC);
        check("same_cyc2.OP", 32'(out_OP), 32'(3'b001));
        check("same_cyc2.ovr", 32'(out_ovr), 32'd0);
        @(posedge clk); #1;
        check("same_cyc2.drop", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_cmd_deserializer.md
Name: alu_cmd_deserializer

Overview:
- Serial-input front end of the ALU. It receives the bit stream on sin from the testbench/host.
- It assembles one command packet: 8 DATA bytes carrying B then A, followed by 1 CTL byte carrying OP and CRC4.
- It checks framing, packet structure, CRC and opcode.
- It presents {A, B, OP, err} to the ALU core over a valid/ready handshake.

Parameters:
- NUM_DATA_BYTES, 8, DATA bytes expected before the CTL byte.
- CRC_W, 4, width of the CRC field in the CTL byte.

Ports:
- clk  in  1  clock; sin sampled on rising edge, one bit per cycle
- RST  in  1  reset, synchronous, active-high
- sin  in  1  serial input; idles high
- out_valid  out  1  command (or error report) available
- out_ready  in  1  core accepts the command when out_valid & out_ready
- out_A  out  32  operand A (signed)
- out_B  out  32  operand B (signed)
- out_OP  out  3  opcode
- out_err  out  3  {ERR_DATA, ERR_CRC, ERR_OP}; at most one bit set
- out_ovr  out  1  sticky: a packet was dropped because the output was still occupied

Behaviour:
- Reset (RST high at posedge clk):
  - all outputs go to 0: out_valid, out_A, out_B, out_OP, out_err, out_ovr.
  - the FSM goes to IDLE and the byte counter clears.
  - reset mid-frame or mid-packet discards all partial data.
- Byte frame, 11 bits: start 0, type (0 = DATA, 1 = CTL), 8 data bits MSB first, stop 1.
- Byte FSM:
  - IDLE: wait for sin == 0 (start bit), then go to TYPE.
  - TYPE: latch the type bit, go to BITS.
  - BITS: shift in 8 bits under a 3-bit counter, go to STOP.
  - STOP: if sin == 1, the byte is complete; otherwise it is a frame error. Both cases return to IDLE. Back-to-back frames (a start bit immediately after stop) are supported.
- Packet assembly:
  - DATA bytes 0..3 shift into B[31:0], MSB first; bytes 4..7 shift into A[31:0].
  - A byte counter runs 0..8.
- A CTL byte arriving with byte_cnt == 8:
  - CTL = {0, OP[2:0], CRC[3:0]}.
  - CRC4 is computed over the 68-bit vector {B, A, 1'b1, OP}: polynomial x^4+x+1, init 0, MSB first.
  - CRC mismatch -> ERR_CRC.
  - Otherwise, OP not in {AND = 000, OR = 001, ADD = 100, SUB = 101} -> ERR_OP.
  - Otherwise no error.
- ERR_DATA conditions:
  - a CTL byte with byte_cnt < 8.
  - a 9th DATA byte (byte_cnt == 8 and type DATA).
  - a frame error (stop bit = 0).
- ERR_DATA handling: report immediately, clear byte_cnt, discard the partial packet.
- Error priority: DATA > CRC > OP.
- Result latency: out_valid rises on the cycle after the CTL stop bit is sampled, or the cycle after the error is detected.
  - On a success report: out_A/out_B/out_OP carry the packet and out_err = 000.
  - On an error report: out_err is set and A/B/OP carry the partial or zero contents. Their values are don't-care to the core.
- Handshake:
  - out_valid and its data are held stable until a cycle with out_ready = 1. out_valid clears in that cycle.
  - Reception continues while out_valid is pending.
  - If a new report completes while out_valid && !out_ready, the new report is dropped and out_ovr is set. out_ovr clears only on RST.
  - A report completing in the same cycle as the handshake of the previous one is loaded; it is not an overrun.
- Repeated idle-high bits are ignored. Glitch filtering is out of scope.

Decomposition:
- alu_pkg holds:
  - op_t enum: AND_OP, OR_OP, ADD_OP, SUB_OP.
  - cmd_t enum: DATA = 0, CTL = 1.
  - err_t constants: ERR_DATA = 3'b100, ERR_CRC = 3'b010, ERR_OP = 3'b001.
  - function crc4(68-bit).
  - localparam FRAME_BITS = 11.
- Sub-module alu_serial_byte_rx:
  - contains the byte FSM.
  - outputs byte_valid pulse, byte_type, byte_data[7:0], frame_err.
  - the packet assembler and CRC/opcode checker stay in the top.

Test Plan:
1. B = 32'h0000_0003, A = 32'h0000_0005, OP = ADD, correct CRC; out_ready held 1 -> one out_valid pulse, A = 5, B = 3, OP = 100, err = 000.
2. Same packet with CRC computed over {B, A, 1'b0, OP} -> out_valid, err = 010.
3. B = 32'hFFFF_FFFF, A = 32'h1, OP = 3'b010 with a valid CRC for that OP -> err = 001.
4. Byte 3 of B sent as CTL type, then a correct full packet -> first report err = 100. Second report OK: A = 1, B = 2, OP = AND.
5. Two back-to-back valid packets with out_ready = 0 -> first report is held unchanged, out_ovr = 1 after the second packet's stop bit. Raising out_ready -> first report accepted, then out_valid = 0.
6. RST asserted after 4 DATA bytes, then a full valid packet (A = 7, B = 9, OR) -> all outputs 0 during reset, then a single clean report with err = 000. Also: a stop bit forced to 0 in a DATA byte -> err = 100.
